mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch path (IF) and the load/store path (MEM stage).
- Sits between the IF/MEM stages and the external memory port. Only one transaction is in flight at a time.
- Data accesses have priority. A starvation counter guarantees fetch progress.
- Uses a registered request/acknowledge handshake on all three interfaces.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
// Latency: grant edge to ack is 2 cycles plus memory wait cycles; back-to-back period 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; memory stalls via i_mem_ready.
//
// Ports: i_inst_* / o_inst_* fetch side, i_data_* / o_data_* load/store side,
//        o_mem_* / i_mem_* external memory port, o_err timeout flag, o_busy not-IDLE.
// Optional: define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles
//           (ack with o_err=1 and rdata 32'hDEADBEEF, or 0 for stores).
module mem_port_arbiter #(
  parameter int DATA_MAX       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_inst_req,
  input  logic [31:0] i_inst_addr,
  output logic        o_inst_ack,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_be,
  output logic        o_data_ack,
  output logic [31:0] o_data_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_err,
  output logic        o_busy
);

  // Parameter sanity checks at elaboration time.
  if (DATA_MAX < 1 || DATA_MAX > 15) begin : g_bad_data_max
    $error("mem_port_arbiter: DATA_MAX must be 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be 2..255");
  end

  localparam logic [3:0] DATA_MAX_L = 4'(DATA_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q;      // 1 = data port owns the transaction, 0 = fetch
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [3:0]  starve_q;
  logic        grant_data, grant_inst;
  logic        timeout;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_q;
`endif

  always_comb begin
    state_d    = state_q;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        // Data wins unless the fetch has already been passed over DATA_MAX times.
        if (i_data_req && (!i_inst_req || (starve_q < DATA_MAX_L))) begin
          grant_data = 1'b1;
          state_d    = ACCESS;
        end else if (i_inst_req) begin
          grant_inst = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (i_mem_ready) begin
          state_d = RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_data) begin
        owner_q <= 1'b1;
        we_q    <= i_data_we;
        addr_q  <= i_data_addr;
        wdata_q <= i_data_wdata;
        be_q    <= i_data_we ? i_data_be : 4'hF;
        err_q   <= 1'b0;
        if (!i_inst_req) begin
          starve_q <= '0;
        end else if (starve_q < DATA_MAX_L) begin
          starve_q <= starve_q + 4'd1;
        end
      end else if (grant_inst) begin
        owner_q  <= 1'b0;
        we_q     <= 1'b0;
        addr_q   <= i_inst_addr;
        wdata_q  <= '0;
        be_q     <= 4'hF;
        err_q    <= 1'b0;
        starve_q <= '0;
      end
      if (state_q == ACCESS) begin
        if (i_mem_ready) begin
          rdata_q <= we_q ? 32'h0 : i_mem_rdata;
        end else if (timeout) begin
          rdata_q <= we_q ? 32'h0 : 32'hDEADBEEF;
          err_q   <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Counts ACCESS cycles; cleared as the grant moves the FSM into ACCESS.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_q <= '0;
    end else if (grant_data || grant_inst) begin
      wait_q <= '0;
    end else if (state_q == ACCESS) begin
      wait_q <= wait_q + 8'd1;
    end
  end
  assign o_err = (state_q == RESP) && err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_mem_req    = (state_q == ACCESS);
  assign o_mem_we     = we_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_be     = be_q;
  assign o_inst_ack   = (state_q == RESP) && !owner_q;
  assign o_data_ack   = (state_q == RESP) && owner_q;
  assign o_inst_rdata = o_inst_ack ? rdata_q : 32'h0;
  assign o_data_rdata = o_data_ack ? rdata_q : 32'h0;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written multi-cycle sequences.
// Latency: n/a (bench).
// Backpressure: drives i_mem_ready per vector; bounded waits on every ack.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        o_inst_ack;
  logic [31:0] o_inst_rdata;
  logic        i_data_req;
  logic        i_data_we;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wdata;
  logic [3:0]  i_data_be;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ready;
  logic        o_err;
  logic        o_busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.DATA_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .o_inst_ack(o_inst_ack), .o_inst_rdata(o_inst_rdata),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .i_data_be(i_data_be),
    .o_data_ack(o_data_ack), .o_data_rdata(o_data_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .o_err(o_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        mrdy;
    logic [31:0] mrdata;
    logic        emreq;
    logic        ewe;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [3:0]  ebe;
    logic        eiack;
    logic        edack;
    logic [31:0] erdata;
    logic        ebusy;
  } vec_t;

  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle;
    i_inst_req   = 1'b0;
    i_inst_addr  = 32'h0;
    i_data_req   = 1'b0;
    i_data_we    = 1'b0;
    i_data_addr  = 32'h0;
    i_data_wdata = 32'h0;
    i_data_be    = 4'h0;
    i_mem_ready  = 1'b0;
    i_mem_rdata  = 32'h0;
  endtask

  task automatic do_reset;
    drive_idle();
    i_rstn = 1'b0;
    tick();
    tick();
    i_rstn = 1'b1;
  endtask

  // Watches acks for up to budget cycles; records owner order, period violations
  // (anything other than 3 cycles between acks), overlapping acks and first ack cycle.
  task automatic collect(input int n, input int budget, output string order,
                         output int gap_bad, output int overlap, output int first_cyc);
    int last;
    int cyc;
    order = "";
    gap_bad = 0;
    overlap = 0;
    first_cyc = -1;
    last = -1;
    cyc = 0;
    while (order.len() < n && cyc < budget) begin
      tick();
      cyc++;
      if (o_inst_ack && o_data_ack) overlap++;
      if (o_inst_ack || o_data_ack) begin
        order = {order, (o_data_ack ? "D" : "I")};
        if (last >= 0 && (cyc - last) != 3) gap_bad++;
        if (first_cyc < 0) first_cyc = cyc;
        last = cyc;
      end
    end
  endtask

  initial begin
    string ord;
    int gap_bad, overlap, first_cyc, acks;

    // {ireq,iaddr,dreq,dwe,daddr,dwdata,dbe,mrdy,mrdata, emreq,ewe,eaddr,ewdata,ebe,eiack,edack,erdata,ebusy}
    vt[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00500093,
               1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1};
    vt[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00500093, 1'b1};
    vt[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 32'h0,
               1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 1'b0, 32'h0, 1'b1};
    vt[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF0000, 32'h0, 4'hC, 1'b0, 32'h0,
               1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 1'b0, 32'h0, 1'b1};
    vt[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 32'h0,
               1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 1'b0, 32'h0, 1'b1};
    vt[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b1, 32'h12345678,
               1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0, 1'b0, 32'h0, 1'b1};
    vt[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vt[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'h0, 1'b1, 32'hA5A51234,
               1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 1'b1};
    vt[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA5A51234, 1'b1};
    vt[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};

    // Reset state: every output low.
    drive_idle();
    i_rstn = 1'b0;
    #12;
    check("rst mem_req", 32'(o_mem_req), 32'h0);
    check("rst mem_addr", o_mem_addr, 32'h0);
    check("rst mem_wdata", o_mem_wdata, 32'h0);
    check("rst mem_be", 32'(o_mem_be), 32'h0);
    check("rst mem_we", 32'(o_mem_we), 32'h0);
    check("rst acks", 32'({o_inst_ack, o_data_ack}), 32'h0);
    check("rst rdata", o_inst_rdata | o_data_rdata, 32'h0);
    check("rst err_busy", 32'({o_err, o_busy}), 32'h0);
    do_reset();

    // Fetch, store with 3 wait states, load.
    for (int k = 0; k < 13; k++) begin
      tick();
      check($sformatf("v%0d mem_req", k), 32'(o_mem_req), 32'(vt[k].emreq));
      if (vt[k].emreq) begin
        check($sformatf("v%0d mem_we", k), 32'(o_mem_we), 32'(vt[k].ewe));
        check($sformatf("v%0d mem_addr", k), o_mem_addr, vt[k].eaddr);
        check($sformatf("v%0d mem_wdata", k), o_mem_wdata, vt[k].ewdata);
        check($sformatf("v%0d mem_be", k), 32'(o_mem_be), 32'(vt[k].ebe));
      end
      check($sformatf("v%0d inst_ack", k), 32'(o_inst_ack), 32'(vt[k].eiack));
      check($sformatf("v%0d data_ack", k), 32'(o_data_ack), 32'(vt[k].edack));
      if (vt[k].eiack) check($sformatf("v%0d inst_rdata", k), o_inst_rdata, vt[k].erdata);
      if (vt[k].edack) check($sformatf("v%0d data_rdata", k), o_data_rdata, vt[k].erdata);
      check($sformatf("v%0d busy", k), 32'(o_busy), 32'(vt[k].ebusy));
      check($sformatf("v%0d err", k), 32'(o_err), 32'h0);
      i_inst_req   = vt[k].ireq;
      i_inst_addr  = vt[k].iaddr;
      i_data_req   = vt[k].dreq;
      i_data_we    = vt[k].dwe;
      i_data_addr  = vt[k].daddr;
      i_data_wdata = vt[k].dwdata;
      i_data_be    = vt[k].dbe;
      i_mem_ready  = vt[k].mrdy;
      i_mem_rdata  = vt[k].mrdata;
    end

    // Both requests held continuously: four data grants then one fetch, period 3.
    do_reset();
    i_inst_req  = 1'b1;
    i_inst_addr = 32'h400;
    i_data_req  = 1'b1;
    i_data_addr = 32'h800;
    i_mem_ready = 1'b1;
    i_mem_rdata = 32'h11;
    collect(10, 60, ord, gap_bad, overlap, first_cyc);
    check_str("starve order", ord, "DDDDIDDDDI");
    check("starve period", 32'(gap_bad), 32'h0);
    check("starve overlap", 32'(overlap), 32'h0);
    check("starve first ack cycle", 32'(first_cyc), 32'h2);

    // Reset in the middle of ACCESS with a nonzero starvation count.
    do_reset();
    i_inst_req  = 1'b1;
    i_data_req  = 1'b1;
    i_mem_ready = 1'b1;
    collect(2, 20, ord, gap_bad, overlap, first_cyc);
    check_str("pre-reset order", ord, "DD");
    i_mem_ready = 1'b0;
    tick();
    tick();
    check("mid access mem_req", 32'(o_mem_req), 32'h1);
    #3;
    i_rstn = 1'b0;
    #1;
    check("async rst mem_req", 32'(o_mem_req), 32'h0);
    check("async rst busy", 32'(o_busy), 32'h0);
    check("async rst mem_addr", o_mem_addr, 32'h0);
    drive_idle();
    i_mem_ready = 1'b1;
    tick();
    i_rstn = 1'b1;
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_inst_ack || o_data_ack) acks++;
    end
    check("no ack after reset", 32'(acks), 32'h0);
    i_inst_req = 1'b1;
    i_inst_addr = 32'h40;
    i_mem_rdata = 32'h13;
    collect(1, 10, ord, gap_bad, overlap, first_cyc);
    check_str("post-reset inst grant", ord, "I");
    check("post-reset inst latency", 32'(first_cyc), 32'h2);
    check("post-reset inst rdata", o_inst_rdata, 32'h13);
    // Starvation count cleared: a full run of four data grants before the fetch.
    i_data_req = 1'b1;
    collect(5, 40, ord, gap_bad, overlap, first_cyc);
    check_str("post-reset starve order", ord, "DDDDI");
    check("post-reset overlap", 32'(overlap), 32'h0);

    // Memory never ready.
    do_reset();
    i_data_req  = 1'b1;
    i_data_addr = 32'h5000;
    tick();
    check("stall entry mem_req", 32'(o_mem_req), 32'h1);
`ifdef MEM_TIMEOUT_EN
    collect(1, 20, ord, gap_bad, overlap, first_cyc);
    check_str("timeout ack owner", ord, "D");
    check("timeout ack cycle", 32'(first_cyc), 32'h8);
    check("timeout err", 32'(o_err), 32'h1);
    check("timeout rdata", o_data_rdata, 32'hDEADBEEF);
`else
    acks = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (o_inst_ack || o_data_ack) acks++;
    end
    check("stall no ack", 32'(acks), 32'h0);
    check("stall busy", 32'(o_busy), 32'h1);
    check("stall mem_req", 32'(o_mem_req), 32'h1);
    check("stall err", 32'(o_err), 32'h0);
`endif
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
